bcd_countdown_n: RTL

Parametrised N-digit BCD countdown timer for game-round and turn timing. It generalises the fixed two-digit cascaded countdown into a single block with the following features:
- configurable digit count
- a run/pause/expired state machine
- optional auto-reload
- a low-time warning flag

It sits between the one-second tick generator and the seven-segment display driver. Load values come from board switches.

---
 rtl/bcd_timer_pkg.sv | 22 ++
 rtl/bcd_countdown_n_if.sv | 26 ++
 rtl/bcd_countdown_n_digit_dec.sv | 29 ++
 rtl/bcd_countdown_n.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types, constants and helpers for the BCD countdown timer.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam int         BCD_NIBBLE = 4;

    function automatic logic [3:0] bcd_sat(input logic [3:0] nibble);
        if (nibble > BCD_MAX) begin
            return BCD_MAX;
        end else begin
            return nibble;
        end
    endfunction

endpackage

// File: rtl/bcd_countdown_n_if.sv
// Control/status bundle between the timer and its controller (switches, tick source, display).
interface bcd_countdown_n_if #(
    parameter int NUM_DIGITS = 2
) ();
    logic                      tick;
    logic                      clear;
    logic                      load_en;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic                      start;
    logic                      pause;
    logic [4*NUM_DIGITS-1:0]   count_out;
    logic                      timeout;
    logic                      expired;
    logic                      running;
    logic                      warn;

    modport master (
        output tick, clear, load_en, load_val, start, pause,
        input  count_out, timeout, expired, running, warn
    );

    modport slave (
        input  tick, clear, load_en, load_val, start, pause,
        output count_out, timeout, expired, running, warn
    );
endinterface

// File: rtl/bcd_countdown_n_digit_dec.sv
// One BCD digit of the ripple-borrow decrementer: 0 with borrow-in wraps to 9 and borrows on.
module bcd_digit_dec
    import bcd_timer_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       borrow_in_i,
    output logic [3:0] digit_next_o,
    output logic       borrow_out_o
);

    // Single-digit subtract with borrow
    always_comb begin
        digit_next_o = digit_i;
        borrow_out_o = 1'b0;
        if (borrow_in_i) begin
            if (digit_i == 4'd0) begin
                digit_next_o = BCD_MAX;
                borrow_out_o = 1'b1;
            end else begin
                digit_next_o = digit_i - 4'd1;
                borrow_out_o = 1'b0;
            end
        end else begin
            digit_next_o = digit_i;
            borrow_out_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_countdown_n.sv
// N-digit BCD countdown timer with run/pause/expired FSM, optional auto-reload and low-time warning.
module bcd_countdown_n
    import bcd_timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int WARN_THRESH = 5
) (
    input logic              clk,
    input logic              rst,
    bcd_countdown_n_if.slave bus
);

    localparam int CW = BCD_NIBBLE * NUM_DIGITS;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_PAUSE   = PAUSE;
    localparam logic [1:0] ST_EXPIRED = EXPIRED;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       reload_q, reload_d;
    logic                timeout_q, timeout_d;
    logic                pend_q, pend_d;

    logic [CW-1:0]       load_sat_s;
    logic [CW-1:0]       dec_s;
    logic [NUM_DIGITS:0] borrow_s;
    logic                cnt_zero_s;
    logic                cnt_one_s;
    logic                go_s;
    logic [31:0]         count_bin_s;

    assign borrow_s[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd_digit_dec u_dec (
            .digit_i      (count_q[g*BCD_NIBBLE +: BCD_NIBBLE]),
            .borrow_in_i  (borrow_s[g]),
            .digit_next_o (dec_s[g*BCD_NIBBLE +: BCD_NIBBLE]),
            .borrow_out_o (borrow_s[g+1])
        );
    end

    // A borrow escaping the top digit means every digit was zero.
    assign cnt_zero_s = borrow_s[NUM_DIGITS];
    assign cnt_one_s  = (count_q == CW'(1));
    assign go_s       = bus.start && !bus.pause;

    // Per-digit saturation of the switch value
    always_comb begin
        load_sat_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_sat_s[i*BCD_NIBBLE +: BCD_NIBBLE] = bcd_sat(bus.load_val[i*BCD_NIBBLE +: BCD_NIBBLE]);
        end
    end

    // BCD count to binary for the warning threshold
    always_comb begin
        count_bin_s = 32'd0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            count_bin_s = (count_bin_s * 32'd10) + {28'd0, count_q[i*BCD_NIBBLE +: BCD_NIBBLE]};
        end
    end

    // FSM and datapath next-state
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        timeout_d = 1'b0;
        pend_d    = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
        end else if (bus.load_en) begin
            count_d  = load_sat_s;
            reload_d = load_sat_s;
            state_d  = ST_IDLE;
        end else if (pend_q) begin
            // Auto-reload cycle after the zero pulse; ticks do not apply here.
            if (reload_q == '0) begin
                state_d = ST_EXPIRED;
            end else begin
                count_d = reload_q;
                state_d = bus.pause ? ST_PAUSE : ST_RUN;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go_s && !cnt_zero_s) state_d = ST_RUN;
                    else                     state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick) begin
                        if (cnt_zero_s) begin
                            state_d = ST_EXPIRED;
                        end else if (cnt_one_s) begin
                            count_d   = '0;
                            timeout_d = 1'b1;
                            if (AUTO_RELOAD) pend_d  = 1'b1;
                            else             state_d = ST_EXPIRED;
                        end else begin
                            count_d = dec_s;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (go_s) state_d = ST_RUN;
                    else      state_d = ST_PAUSE;
                end
                ST_EXPIRED: begin
                    if (go_s && (reload_q != '0)) begin
                        count_d = reload_q;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_EXPIRED;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            timeout_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            timeout_q <= timeout_d;
            pend_q    <= pend_d;
        end
    end

    assign bus.count_out = count_q;
    assign bus.timeout   = timeout_q;
    assign bus.expired   = (state_q == ST_EXPIRED);
    assign bus.running   = (state_q == ST_RUN);
    assign bus.warn      = (state_q == ST_RUN) && !cnt_zero_s && (count_bin_s <= 32'(WARN_THRESH));

endmodule
